router_dst_port: RTL

Parametrised destination-side output port for the router family. It generalises the 1x3 destination interface to configurable data width, buffer depth and timeout. The block buffers bytes for one output channel in a FIFO that marks packet headers, and presents them to the receiver with a valid_out/read_enable handshake. If the receiver does not read within TIMEOUT cycles, the block flushes itself.
One instance sits per router output channel, between the router core write path and the destination agent.

---
 rtl/router_dst_port.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/router_dst_port.sv
// Destination-side output port: header-tagged FIFO with valid_out/read_enable
// handshake and a self-flush when the receiver stalls for TIMEOUT cycles.
module router_dst_port #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned TIMEOUT    = 30,
    parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  write_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sof_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic [CNT_W-1:0]      hdr_count,
    output logic                  soft_reset
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    // Storage entry: {header flag, data byte}
    logic [EW-1:0]         r_mem [DEPTH];

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]      r_hdr_count;
    logic [TW-1:0]         r_timer;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_sof_out;
    logic                  r_soft_reset;

    logic [PW-1:0]         w_wr_ptr_nxt;
    logic [PW-1:0]         w_rd_ptr_nxt;
    logic [CNT_W-1:0]      w_hdr_count_nxt;
    logic [TW-1:0]         w_timer_nxt;
    logic [DATA_WIDTH-1:0] w_data_out_nxt;
    logic                  w_sof_out_nxt;
    logic                  w_soft_reset_nxt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_flush;
    logic                  w_mem_we;
    logic                  w_wr_hdr;
    logic                  w_rd_hdr;
    logic [EW-1:0]         w_head;

    // Occupancy flags from the wrap-bit pointer pair
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_wr_acc = write_enb && !w_full;
    assign w_rd_acc = read_enable && !w_empty;

    // Stalled receiver: last unread cycle before the flush edge
    assign w_flush  = !w_empty && !read_enable && (r_timer == TW'(TIMEOUT - 1));

    assign w_mem_we = w_wr_acc && !w_flush;
    assign w_wr_hdr = w_mem_we && lfd_state;
    assign w_rd_hdr = w_rd_acc && w_head[DATA_WIDTH];

    // Next-state logic
    always_comb begin
        w_wr_ptr_nxt     = r_wr_ptr;
        w_rd_ptr_nxt     = r_rd_ptr;
        w_hdr_count_nxt  = r_hdr_count;
        w_timer_nxt      = r_timer;
        w_data_out_nxt   = r_data_out;
        w_sof_out_nxt    = r_sof_out;
        w_soft_reset_nxt = 1'b0;

        if (w_flush) begin
            w_wr_ptr_nxt     = '0;
            w_rd_ptr_nxt     = '0;
            w_hdr_count_nxt  = '0;
            w_timer_nxt      = '0;
            w_soft_reset_nxt = 1'b1;
        end else begin
            if (w_wr_acc) begin
                w_wr_ptr_nxt = r_wr_ptr + PW'(1);
            end

            if (w_rd_acc) begin
                w_rd_ptr_nxt   = r_rd_ptr + PW'(1);
                w_data_out_nxt = w_head[DATA_WIDTH-1:0];
                w_sof_out_nxt  = w_head[DATA_WIDTH];
            end

            case ({w_wr_hdr, w_rd_hdr})
                2'b10:   w_hdr_count_nxt = r_hdr_count + CNT_W'(1);
                2'b01:   w_hdr_count_nxt = r_hdr_count - CNT_W'(1);
                default: w_hdr_count_nxt = r_hdr_count;
            endcase

            if (w_empty || w_rd_acc) begin
                w_timer_nxt = '0;
            end else begin
                w_timer_nxt = r_timer + TW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_hdr_count  <= '0;
            r_timer      <= '0;
            r_data_out   <= '0;
            r_sof_out    <= 1'b0;
            r_soft_reset <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_hdr_count  <= w_hdr_count_nxt;
            r_timer      <= w_timer_nxt;
            r_data_out   <= w_data_out_nxt;
            r_sof_out    <= w_sof_out_nxt;
            r_soft_reset <= w_soft_reset_nxt;
        end
    end

    // Storage array needs no reset; validity is tracked by the pointers
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    assign data_out   = r_data_out;
    assign sof_out    = r_sof_out;
    assign soft_reset = r_soft_reset;
    assign hdr_count  = r_hdr_count;
    assign valid_out  = !w_empty;
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = CNT_W'(r_wr_ptr - r_rd_ptr);

endmodule
